conv1d_branch_ctrl: RTL and testbench
=====================================

Name: conv1d_branch_ctrl

Overview:
- Sequencer for one conv1d branch (5 data regs, 5 weight regs, shared 5:1 tap mux, multiplier).
- Takes one input stream, routes beats to the branch as weights or window samples, and steps the tap select over 5 cycles.
- Accumulates the 5 tap products into one dot-product result per window and emits it on a valid/ready output.
- Sits between the conv1d stream/config front-end and one branch instance.

Parameters:
WIDTH, 8, sample/weight width; branch product width is 4*WIDTH
ACC_W, 4*WIDTH+3, accumulator/result width (holds 5 products without overflow)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; honoured only in IDLE
load_w  in  1  sampled with start; 1 = job begins with 5 weight beats
n_out  in  16  sampled with start; number of windows/results in the job
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the job completes
s_valid  in  1  input stream valid
s_ready  out  1  input stream ready
s_data  in  WIDTH  input stream data (weights or samples)
in_branch  out  WIDTH  to branch data input; always equals s_data
ld_data  out  5  one-hot data-register load to branch
rst_data  out  5  data-register clear to branch
ld_weight  out  5  one-hot weight-register load to branch
sel  out  3  tap select to branch, 0..4
prod  in  4*WIDTH  branch product for the current sel (combinational in branch)
m_valid  out  1  result valid
m_ready  in  1  result ready
m_data  out  ACC_W  result, unsigned sum of 5 products

Behaviour:
- All arithmetic is unsigned. prod is zero-extended to ACC_W.
- Reset (async, rst_n=0): state IDLE; idx, out_cnt, acc = 0; m_valid, done, busy = 0; sel = 0; rst_data = 0; s_ready = 0.
- FSM states: IDLE, CLR, LD_W, LD_D, MAC, OUT.
- IDLE:
  - s_ready = 0; ld_* = 0.
  - start=1: latch load_w and n_out, clear out_cnt, go to CLR.
  - start is ignored in every other state.
- CLR (1 cycle):
  - rst_data = 5'h1F; weight registers are untouched.
  - Next state: n_out==0 → IDLE with done pulse; load_w → LD_W; otherwise LD_D with idx=0.
- LD_W:
  - s_ready = 1.
  - On handshake (s_valid & s_ready): ld_weight = 1<<idx in the same cycle (combinational), idx++.
  - On the 5th handshake: idx=0, go to LD_D.
- LD_D:
  - Same as LD_W but drives ld_data.
  - On the 5th handshake: go to MAC with sel=0.
- Stalls: s_valid gaps stall LD_W/LD_D indefinitely, with ld_* = 0 during the gap.
- MAC: exactly 5 cycles, sel = 0,1,2,3,4 (registered).
  - sel=0: acc <= prod.
  - sel=1..4: acc <= acc + prod.
  - After sel=4: go to OUT, sel back to 0.
- OUT:
  - m_valid = 1, m_data = acc; both held stable until m_ready. s_ready = 0.
  - On handshake: out_cnt++.
  - If out_cnt+1 == n_out: go to IDLE and pulse done in the next cycle.
  - Otherwise go to LD_D, idx=0.
- Weights persist across jobs. A job with load_w=0 reuses the last loaded weights.
- Throughput with continuous s_valid/m_ready:
  - 1 cycle CLR.
  - 5 cycles of weights (load_w=1 only).
  - 11 cycles per result (5 load + 5 MAC + 1 OUT).
  - First result is visible 16 cycles after start when load_w=1.
- done and m_valid are never high in the same cycle.
- Reset asserted mid-job: immediate return to IDLE with all outputs at reset values; partial acc is discarded.
- n_out is not re-sampled mid-job; changing the input while busy has no effect.

Test Plan:
- Weights 1..5, data 1,1,1,1,1, load_w=1, n_out=1 → one result m_data=15; done pulses one cycle after the handshake; busy then low; rst_data=1F seen for exactly one cycle after start.
- Weights 255×5, data 255×5 → m_data=325125 (no overflow at WIDTH=8).
- n_out=2, windows {1,2,3,4,5} and {0,0,0,0,1} with weights 1..5 → results 55 then 5; then a second job with load_w=0 and data 1×5 → 15 (weights retained).
- m_ready held low 10 cycles in OUT → m_valid/m_data stable and s_ready=0 throughout; start pulse during busy ignored.
- s_valid toggling 1/0 during LD_D → ld_data one-hot only on handshake cycles, order 00001→10000; n_out=0 → CLR then done, no m_valid.
- rst_n dropped during MAC (sel=2) → all outputs at reset values asynchronously; a new job after release gives the correct result.

Source files
------------

// File: rtl/conv1d_branch_ctrl.sv
// Sequencer for one conv1d branch: loads weights and window samples,
// steps the tap select over 5 MAC cycles and emits one dot product per window.
module conv1d_branch_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 4*WIDTH+3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_w,
  input  logic [15:0]        n_out,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic [WIDTH-1:0]   in_branch,
  output logic [4:0]         ld_data,
  output logic [4:0]         rst_data,
  output logic [4:0]         ld_weight,
  output logic [2:0]         sel,
  input  logic [4*WIDTH-1:0] prod,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ACC_W-1:0]   m_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LDW  = 3'd2;
  localparam logic [2:0] S_LDD  = 3'd3;
  localparam logic [2:0] S_MAC  = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       sel_q, sel_d;
  logic [15:0]      out_cnt_q, out_cnt_d;
  logic [15:0]      n_out_q, n_out_d;
  logic             load_w_q, load_w_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [4:0]       idx_oh;
  logic             hs_in;

  assign prod_ext  = {{(ACC_W-4*WIDTH){1'b0}}, prod};
  assign idx_oh    = 5'b00001 << idx_q;
  assign s_ready   = (state_q == S_LDW) | (state_q == S_LDD);
  assign hs_in     = s_valid & s_ready;
  assign ld_weight = (state_q == S_LDW && s_valid) ? idx_oh : 5'b0;
  assign ld_data   = (state_q == S_LDD && s_valid) ? idx_oh : 5'b0;
  assign rst_data  = (state_q == S_CLR) ? 5'h1F : 5'h00;
  assign in_branch = s_data;
  assign sel       = sel_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign m_valid   = (state_q == S_OUT);
  assign m_data    = acc_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    out_cnt_d = out_cnt_q;
    n_out_d   = n_out_q;
    load_w_d  = load_w_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_w_d  = load_w;
          n_out_d   = n_out;
          out_cnt_d = '0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        idx_d = '0;
        if (n_out_q == 16'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (load_w_q) begin
          state_d = S_LDW;
        end else begin
          state_d = S_LDD;
        end
      end
      S_LDW: begin
        if (hs_in) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = S_LDD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_LDD: begin
        if (hs_in) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            sel_d   = '0;
            state_d = S_MAC;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_MAC: begin
        // Tap 0 restarts the sum so no separate clear cycle is needed
        acc_d = (sel_q == 3'd0) ? prod_ext : acc_q + prod_ext;
        if (sel_q == 3'd4) begin
          sel_d   = '0;
          state_d = S_OUT;
        end else begin
          sel_d = sel_q + 3'd1;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          out_cnt_d = out_cnt_q + 16'd1;
          if (out_cnt_q + 16'd1 == n_out_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = S_LDD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      sel_q     <= '0;
      out_cnt_q <= '0;
      n_out_q   <= '0;
      load_w_q  <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      out_cnt_q <= out_cnt_d;
      n_out_q   <= n_out_d;
      load_w_q  <= load_w_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_conv1d_branch_ctrl.sv
// Directed bench for conv1d_branch_ctrl with a behavioural branch model
// and a queue of expected dot products.
module tb_conv1d_branch_ctrl;

  localparam int WIDTH = 8;
  localparam int ACC_W = 4*WIDTH+3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               load_w;
  logic [15:0]        n_out;
  logic               busy;
  logic               done;
  logic               s_valid;
  logic               s_ready;
  logic [WIDTH-1:0]   s_data;
  logic [WIDTH-1:0]   in_branch;
  logic [4:0]         ld_data;
  logic [4:0]         rst_data;
  logic [4:0]         ld_weight;
  logic [2:0]         sel;
  logic [4*WIDTH-1:0] prod;
  logic               m_valid;
  logic               m_ready;
  logic [ACC_W-1:0]   m_data;

  conv1d_branch_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w),
    .n_out(n_out), .busy(busy), .done(done), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .in_branch(in_branch),
    .ld_data(ld_data), .rst_data(rst_data), .ld_weight(ld_weight),
    .sel(sel), .prod(prod), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  // Behavioural branch: registers driven by the controller strobes
  logic [WIDTH-1:0] br_w [5];
  logic [WIDTH-1:0] br_d [5];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst_data[i]) br_d[i] <= '0;
      else if (ld_data[i]) br_d[i] <= in_branch;
      if (ld_weight[i]) br_w[i] <= in_branch;
    end
  end

  always_comb begin
    prod = '0;
    if (sel < 3'd5) prod = br_w[sel] * br_d[sel];
  end

  int vecs = 0;
  int errs = 0;
  logic [63:0] exp_q [$];
  logic [WIDTH-1:0] tb_w [5];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic lw, input logic [15:0] n);
    start = 1'b1; load_w = lw; n_out = n;
    @(negedge clk);
    start = 1'b0; load_w = 1'b0; n_out = 16'd7;
    #1;
    check("clr_rst_data", rst_data, 5'h1F);
    check("clr_busy", busy, 1'b1);
  endtask

  task automatic send(input logic [39:0] v, input bit is_w, input bit gap);
    int n;
    logic [63:0] sum;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = v[8*i +: 8];
      #1;
      n = 0;
      while (!s_ready && n < 50) begin
        @(negedge clk); #1; n++;
      end
      check("s_ready_wait", n < 50, 1'b1);
      if (is_w) check("ld_weight", ld_weight, 5'b00001 << i);
      else      check("ld_data", ld_data, 5'b00001 << i);
      @(negedge clk);
      if (gap && i < 4) begin
        s_valid = 1'b0;
        #1;
        check("gap_ld", {ld_data, ld_weight}, 10'd0);
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    if (is_w) begin
      for (int i = 0; i < 5; i++) tb_w[i] = v[8*i +: 8];
    end else begin
      sum = 0;
      for (int i = 0; i < 5; i++) sum += 64'(tb_w[i]) * 64'(v[8*i +: 8]);
      exp_q.push_back(sum);
    end
  endtask

  task automatic get_result(input int hold);
    int n;
    logic [63:0] exp;
    n = 0;
    #1;
    while (!m_valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("m_valid_seen", m_valid, 1'b1);
    check("no_done_with_valid", done, 1'b0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check("m_data", 64'(m_data), exp);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin start = 1'b1; load_w = 1'b1; n_out = 16'd0; end
      @(negedge clk);
      start = 1'b0;
      #1;
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", 64'(m_data), exp);
      check("hold_s_ready", s_ready, 1'b0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_done();
    check("done_pulse", done, 1'b1);
    check("busy_low", busy, 1'b0);
    check("m_valid_low", m_valid, 1'b0);
    @(negedge clk);
    #1;
    check("done_clear", done, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; load_w = 1'b0; n_out = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_sel", sel, 3'd0);
    check("rst_rst_data", rst_data, 5'd0);
    check("rst_ld", {ld_data, ld_weight}, 10'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // weights 1..5, ones
    do_start(1'b1, 16'd1);
    @(negedge clk); #1;
    check("clr_once", rst_data, 5'd0);
    send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b0);
    send({8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);
    get_result(0);
    expect_done();

    // two windows, then weight reuse
    do_start(1'b1, 16'd2);
    send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b0);
    send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0);
    get_result(0);
    check("mid_job_busy", busy, 1'b1);
    check("mid_job_done", done, 1'b0);
    send({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b0);
    get_result(0);
    expect_done();
    do_start(1'b0, 16'd1);
    send({8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);
    get_result(0);
    expect_done();

    // full-scale operands
    do_start(1'b1, 16'd1);
    send({5{8'd255}}, 1'b1, 1'b0);
    send({5{8'd255}}, 1'b0, 1'b0);
    get_result(0);
    expect_done();

    // output backpressure with a stray start
    m_ready = 1'b0;
    do_start(1'b0, 16'd1);
    send({5{8'd2}}, 1'b0, 1'b0);
    get_result(10);
    expect_done();
    repeat (3) @(negedge clk);
    #1;
    check("stray_start_ignored", busy, 1'b0);

    // gapped input stream
    do_start(1'b0, 16'd1);
    send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b1);
    get_result(0);
    expect_done();

    // empty job
    do_start(1'b1, 16'd0);
    @(negedge clk); #1;
    check("empty_m_valid", m_valid, 1'b0);
    expect_done();

    // reset in the middle of MAC
    do_start(1'b0, 16'd1);
    send({5{8'd3}}, 1'b0, 1'b0);
    n = 0;
    #1;
    while (sel != 3'd2 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("reach_sel2", sel, 3'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_busy", busy, 1'b0);
    check("arst_sel", sel, 3'd0);
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_s_ready", s_ready, 1'b0);
    check("arst_m_data", 64'(m_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1'b1, 16'd1);
    send({5{8'd2}}, 1'b1, 1'b0);
    send({8'd5, 8'd1, 8'd4, 8'd1, 8'd3}, 1'b0, 1'b0);
    get_result(0);
    expect_done();
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
